// File: rtl/sbox_scheduler.sv
// ============================================================================
//  Module   : sbox_scheduler
//  Purpose  : Iterative DES f-function S-box sequencer. Takes one 48-bit
//             expanded, key-mixed word and walks a single shared S-box bank
//             port through S1..S8, one box per cycle. It packs the eight
//             4-bit results into the 32-bit pre-permutation word and returns
//             it over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_scheduler #(
  // Bank read latency: 0 = combinational bank, 1 = registered bank output
  parameter int SB_LAT = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [47:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  input  logic        i_flush,
  output logic [2:0]  o_sb_sel,
  output logic [5:0]  o_sb_addr,
  input  logic [3:0]  i_sb_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  issue_cnt;
  // Remaining six-bit chunks of the latched word; S1's chunk goes straight
  // to the address register at acceptance, so only 42 bits are kept.
  logic [41:0] pending;
  logic        capture;

  // Bank data is valid on every ISSUE cycle for a combinational bank; with a
  // registered bank it trails by one cycle, so box 0 is skipped on the first
  // ISSUE cycle and box 7 is picked up in DRAIN.
  always_comb begin
    capture = 1'b0;
    if (SB_LAT == 0) begin
      capture = (state == ST_ISSUE);
    end else begin
      capture = ((state == ST_ISSUE) && (issue_cnt != 3'd0)) || (state == ST_DRAIN);
    end
  end

  // Control FSM with registered handshake, lookup and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      issue_cnt <= 3'd0;
      pending   <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_sb_sel  <= 3'd0;
      o_sb_addr <= 6'd0;
      o_busy    <= 1'b0;
    end else if (i_flush) begin
      state     <= ST_IDLE;
      issue_cnt <= 3'd0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_sb_sel  <= 3'd0;
      o_sb_addr <= 6'd0;
      o_busy    <= 1'b0;
    end else begin
      // Results shift in from the bottom, so S1 ends up in bits [31:28].
      if (capture) begin
        o_data <= {o_data[27:0], i_sb_data};
      end
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            state     <= ST_ISSUE;
            issue_cnt <= 3'd0;
            pending   <= i_data[41:0];
            o_data    <= '0;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            o_sb_sel  <= 3'd0;
            o_sb_addr <= i_data[47:42];
          end
        end
        ST_ISSUE: begin
          if (issue_cnt == 3'd7) begin
            o_sb_sel  <= 3'd0;
            o_sb_addr <= 6'd0;
            if (SB_LAT == 0) begin
              state   <= ST_DONE;
              o_valid <= 1'b1;
            end else begin
              state   <= ST_DRAIN;
            end
          end else begin
            issue_cnt <= issue_cnt + 3'd1;
            o_sb_sel  <= issue_cnt + 3'd1;
            o_sb_addr <= pending[41:36];
            pending   <= {pending[35:0], 6'd0};
          end
        end
        ST_DRAIN: begin
          state   <= ST_DONE;
          o_valid <= 1'b1;
        end
        ST_DONE: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sbox_scheduler.md
# sbox_scheduler

Iterative S-box sequencer for the DES f-function. It accepts one 48-bit expanded, key-mixed word and time-multiplexes a single shared S-box lookup port across S1..S8, one box per cycle. It assembles the eight 4-bit results into the 32-bit pre-permutation word and returns it over a valid/ready handshake. It sits between the round XOR stage and the P-permutation, and drives the external S-box bank mux (sbox1..sbox8, selected by box index).

## Interface
- SB_LAT, default 0: S-box bank read latency in cycles.
  - 0: the bank is combinational.
  - 1: the bank output is registered.
  - Other values are illegal.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  input word valid.
- o_ready  output  1  scheduler can accept a word.
- i_data  input  48  f-function input. Bits [47:42] feed S1, and so on down to bits [5:0] for S8.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_data  output  32  result. Bits [31:28] come from S1, and so on down to bits [3:0] from S8.
- i_flush  input  1  abandon any operation in flight.
- o_sb_sel  output  3  box index presented to the bank (0 = S1 … 7 = S8).
- o_sb_addr  output  6  raw 6-bit lookup index. Row/column decoding is done inside the bank.
- i_sb_data  input  4  bank result.
- o_busy  output  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, DRAIN (SB_LAT=1 only), DONE.
- IDLE
  - o_ready=1.
  - On i_valid & o_ready: latch i_data into a 48-bit shift register, clear the issue counter and the result register, go to ISSUE.
- ISSUE
  - o_sb_sel = issue count k; o_sb_addr = i_data[47-6k -: 6] of the latched word.
  - k increments each cycle, 0..7.
  - SB_LAT=0: i_sb_data is captured into o_data[31-4k -: 4] on the same edge that advances k. After k=7 is captured, go to DONE.
  - SB_LAT=1: the capture index trails the issue index by one cycle, so the capture for box k happens while box k+1 is issued. After k=7 is issued, go to DRAIN.
- DRAIN (SB_LAT=1 only): capture box 7, go to DONE.
- DONE
  - o_valid=1; o_data is stable and unchanged while i_ready=0.
  - On i_ready: go to IDLE.
- o_sb_sel and o_sb_addr read 0 outside ISSUE. The bank ignores them outside ISSUE.
- i_flush: on the next edge, go to IDLE from any state. o_valid deasserts and the partial result is discarded. i_flush has priority over acceptance and completion on the same edge.
- i_rst has priority over i_flush.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_data=0, o_sb_sel=0, o_sb_addr=0, o_busy=0.

## Timing
- Accept on edge E0. First lookup (S1) is driven in the cycle after E0.
- SB_LAT=0: captures at E1..E8; o_valid high from E8.
- SB_LAT=1: issues after E0..E7, captures at E2..E9; o_valid high from E9.
- Latency from accept to o_valid: 8 cycles (SB_LAT=0) or 9 cycles (SB_LAT=1).
- o_ready is high only in IDLE. It is low from E0 until the edge after the o_valid & i_ready handshake.
- Minimum accept-to-accept spacing with i_ready tied high:
  - SB_LAT=0: 10 cycles (8 lookup cycles, the DONE handshake cycle, one IDLE accept cycle).
  - SB_LAT=1: 11 cycles.
- i_data is sampled only at acceptance. Changes after acceptance have no effect.
- i_valid held while o_ready=0 is ignored, not queued.
- i_rst asserted mid-ISSUE: outputs take their reset values on that edge. No result is emitted.

## Test plan
Expected values assume the bench models the bank with the standard DES S1..S8 tables.
- Reset then idle: hold i_rst 2 cycles -> o_ready=1, o_valid=0, o_data=0, o_busy=0.
- SB_LAT=0, i_data=48'h000000000000, i_ready=1:
  - o_sb_sel steps 0..7 with o_sb_addr=0 throughout.
  - o_valid rises 8 cycles after accept with o_data=32'hEFA72C4D, held for 1 cycle.
- SB_LAT=0, i_data=48'hFFFFFFFFFFFF, i_ready=0 for 5 cycles after o_valid, then 1:
  - o_data=32'hD9CE3DCB, stable for all 6 valid cycles.
  - o_ready reasserts the cycle after the handshake.
- SB_LAT=1, same two vectors back-to-back with i_valid held high:
  - Results are EFA72C4D then D9CE3DCB, each valid 9 cycles after its accept.
  - The second word is accepted exactly 11 cycles after the first.
  - No lookup in DRAIN or DONE.
- i_flush pulse while o_sb_sel=3 -> next cycle IDLE, o_valid never asserts. A following word 48'h0 still yields 32'hEFA72C4D.
- i_rst and i_flush asserted together mid-ISSUE -> reset values. i_valid asserted during that cycle is not accepted.
